// File: rtl/toggle_rr_arbiter.sv
// Round-robin ownership arbiter for one shared toggle bit, with a burst limit that forces rotation.
// Define TOGGLE_ARB_STATS_EN to add the saturating toggle_count / rotate_count outputs.
module toggle_rr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] toggle_en,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic             out,
`ifdef TOGGLE_ARB_STATS_EN
    output logic [15:0]      toggle_count,
    output logic [15:0]      rotate_count,
`endif
    output logic             busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [PW-1:0] LAST_IDX   = PW'(N_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [PW-1:0]    owner_q;
    logic [PW-1:0]    ptr_q;
    logic [BW-1:0]    burst_q;
    logic             out_q;

    logic [PW-1:0]    rel_ptr;
    logic [PW-1:0]    search_base;
    logic             pick_found;
    logic [PW-1:0]    pick_idx;
    logic             owner_tog;
    logic             at_limit;
    logic             release_now;
    logic             out_d;
    logic [BW-1:0]    burst_d;

    always_comb begin
        rel_ptr     = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        // On release the search starts just past the outgoing owner, so no dead cycle is needed
        search_base = (state_q == GRANT) ? rel_ptr : ptr_q;
        pick_found  = 1'b0;
        pick_idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_found && req[(int'(search_base) + i) % N_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = PW'((int'(search_base) + i) % N_REQ);
            end
        end
        owner_tog   = (state_q == GRANT) && toggle_en[owner_q];
        at_limit    = (burst_q == BURST_LAST);
        release_now = (state_q == GRANT) && (!req[owner_q] || at_limit);
        out_d       = out_q ^ owner_tog;
        burst_d     = at_limit ? burst_q : burst_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
            out_q   <= 1'b0;
        end else begin
            out_q <= out_d;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= N_REQ'(1) << pick_idx;
                        owner_q <= pick_idx;
                        burst_q <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr_q <= rel_ptr;
                        if (pick_found) begin
                            grant_q <= N_REQ'(1) << pick_idx;
                            owner_q <= pick_idx;
                            burst_q <= '0;
                        end else begin
                            grant_q <= '0;
                            burst_q <= '0;
                            state_q <= IDLE;
                        end
                    end else begin
                        burst_q <= burst_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign busy        = grant_valid;
    assign out         = out_q;

`ifdef TOGGLE_ARB_STATS_EN
    logic [15:0] toggle_cnt_q;
    logic [15:0] rotate_cnt_q;

    // A forced rotation is one where the owner still wanted the resource
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            toggle_cnt_q <= '0;
            rotate_cnt_q <= '0;
        end else begin
            if (owner_tog && toggle_cnt_q != 16'hFFFF)
                toggle_cnt_q <= toggle_cnt_q + 16'd1;
            if (release_now && req[owner_q] && at_limit && rotate_cnt_q != 16'hFFFF)
                rotate_cnt_q <= rotate_cnt_q + 16'd1;
        end
    end

    assign toggle_count = toggle_cnt_q;
    assign rotate_count = rotate_cnt_q;
`endif

endmodule

// File: doc/toggle_rr_arbiter.md
Name: toggle_rr_arbiter

Overview:
Round-robin arbiter and sequencer for a single shared 1-bit toggle register. Up to N_REQ requesters compete for ownership; only the current owner may flip the shared bit. A burst limit forces rotation so no requester can starve the others. Sits between multiple control agents and the single toggle resource they share.

Parameters:
N_REQ, 4, number of requesters (1..16)
MAX_BURST, 4, max consecutive grant cycles per ownership before forced rotation (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted at 0)
req  input  N_REQ  per-requester ownership request, level
toggle_en  input  N_REQ  per-requester toggle command; honoured only for the current owner
grant  output  N_REQ  one-hot owner indication, registered; all zero when idle
grant_valid  output  1  high when any grant bit is set
out  output  1  shared toggle bit
busy  output  1  equals grant_valid; one-cycle-aligned status for upstream logic

Behaviour:
- Reset (rst=0, async): grant=0, grant_valid=0, busy=0, out=0, rr pointer=0, burst_cnt=0, state=IDLE. Release is synchronous to clk.
- State IDLE: grant=0. If any req bit is sampled high, select the first set bit searching circularly from the rr pointer, load grant one-hot at that edge, burst_cnt=0, go to GRANT. Latency: req high at edge t gives grant high after edge t.
- State GRANT, owner k:
  - Every cycle with grant[k]=1 and toggle_en[k]=1: out inverts at the next edge. toggle_en from non-owners is ignored in all states.
  - burst_cnt increments each GRANT cycle and saturates at MAX_BURST-1.
  - Release condition at an edge: req[k]=0, or burst_cnt==MAX_BURST-1.
  - On release: rr pointer=(k+1) mod N_REQ. Search req from the new pointer. If any bit is set, grant it at the same edge (no dead cycle) and clear burst_cnt. Requester k itself is eligible if it is the only one requesting. If no bit is set, grant=0 and go to IDLE.
  - A toggle_en on the release cycle still applies; ownership of that cycle belongs to k.
- Owner dropping req while toggle_en is high: the toggle still applies on that cycle; the grant clears at the same edge.
- grant is always one-hot or zero; never two bits set.
- MAX_BURST=1: ownership rotates every cycle while multiple requesters are active.
- N_REQ=1: the single requester is re-granted continuously; burst_cnt still wraps each MAX_BURST cycles, with no grant gap.
- Reset mid-burst: all state clears immediately, including out; pending req is re-arbitrated from pointer 0 after reset release.

Optional Feature:
TOGGLE_ARB_STATS_EN
- Defined: adds output toggle_count[15:0], a saturating count (stops at 16'hFFFF) of accepted toggles; it increments on every edge where out changes. It also adds output rotate_count[15:0], a saturating count of forced (burst-limit) releases. Both reset to 0.
- Undefined: neither port nor its counters exist; the rest of the behaviour is identical.

Test Plan:
- Reset check: hold rst=0 with random req/toggle_en -> grant=0, grant_valid=0, busy=0, out=0 throughout.
- Single requester: req=4'b0010 from cycle 1 and toggle_en[1] held high, MAX_BURST=4 -> grant=4'b0010 from cycle 2, out toggles every cycle, grant never drops.
- Fair rotation: req=4'b1111 held, MAX_BURST=4 -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again, with no idle cycle between owners.
- Non-owner masking: owner=0, toggle_en=4'b1110 for 3 cycles -> out unchanged; toggle_en=4'b0001 for 1 cycle -> out flips exactly once.
- Early release: owner 2 drops req after 2 cycles while req[3]=1 -> grant moves to 4'b1000 at the same edge; with no other req, grant goes to 0 and the FSM returns to IDLE.
- Async reset mid-burst: assert rst=0 between clock edges during GRANT with out=1 -> out, grant and busy clear immediately; after release with req=4'b1000, requester 3 is granted.
